// File: rtl/trig_pkg.sv
// Shared definitions for the trigger comparator: edge modes, FSM states and
// the saturating bound arithmetic used to build the hysteresis window.
package trig_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_t;

    // Working width of the bound helpers; callers cast the result down.
    localparam int SAT_W = 32;

    // a + b clamped to the largest unsigned value representable in w bits.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
        if (sum > lim) return lim[SAT_W-1:0];
        return sum[SAT_W-1:0];
    endfunction

    // a - b clamped at zero instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        if (b > a) return '0;
        return a - b;
    endfunction

endpackage

// File: rtl/hyst_channel.sv
// One comparator channel: stage 1 captures the sample and the saturated
// window bounds, stage 2 resolves the hysteresis level, dead-zone flag and
// edge pulses.
module hyst_channel
    import trig_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_thr,
    input  logic [DATA_W-1:0] i_hyst,
    output logic              o_q,
    output logic              o_z,
    output logic              o_rise,
    output logic              o_fall
);

    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_lower;
    logic [DATA_W-1:0] r_sample_p1;
    logic [DATA_W-1:0] r_upper_p1;
    logic [DATA_W-1:0] r_lower_p1;
    logic              w_above;
    logic              w_below;
    logic              r_q_p2;
    logic              r_z_p2;
    logic              r_vld_p2;
    logic              r_rise_p2;
    logic              r_fall_p2;
    logic              r_en_d;

    assign w_upper = DATA_W'(sat_add(SAT_W'(i_thr), SAT_W'(i_hyst), DATA_W));
    assign w_lower = DATA_W'(sat_sub(SAT_W'(i_thr), SAT_W'(i_hyst)));

    // Stage 1: capture sample with its window; frozen while disabled.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_sample_p1 <= i_sample;
            r_upper_p1  <= w_upper;
            r_lower_p1  <= w_lower;
        end
    end

    // Samples equal to either bound fall in the dead zone.
    assign w_above = (r_sample_p1 > r_upper_p1);
    assign w_below = (r_sample_p1 < r_lower_p1);

    // Stage 2: level/dead-zone update; edges only from a valid prior level
    // and never on the first enabled cycle after a disable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q_p2    <= 1'b0;
            r_z_p2    <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_rise_p2 <= 1'b0;
            r_fall_p2 <= 1'b0;
            r_en_d    <= 1'b0;
        end else begin
            r_en_d <= i_en;
            if (!i_en) begin
                r_rise_p2 <= 1'b0;
                r_fall_p2 <= 1'b0;
            end else if (w_above) begin
                r_rise_p2 <= r_vld_p2 && !r_q_p2 && r_en_d;
                r_fall_p2 <= 1'b0;
                r_q_p2    <= 1'b1;
                r_z_p2    <= 1'b0;
                r_vld_p2  <= 1'b1;
            end else if (w_below) begin
                r_rise_p2 <= 1'b0;
                r_fall_p2 <= r_vld_p2 && r_q_p2 && r_en_d;
                r_q_p2    <= 1'b0;
                r_z_p2    <= 1'b0;
                r_vld_p2  <= 1'b1;
            end else begin
                r_rise_p2 <= 1'b0;
                r_fall_p2 <= 1'b0;
                r_z_p2    <= 1'b1;
            end
        end
    end

    assign o_q    = r_q_p2;
    assign o_z    = r_z_p2;
    assign o_rise = r_rise_p2;
    assign o_fall = r_fall_p2;

endmodule

// File: rtl/trig_comparator_multi.sv
// Multi-channel hysteresis comparator with an armed trigger engine:
// N_CH comparator channels feed a shared IDLE/ARMED/HOLDOFF FSM.
module trig_comparator_multi
    import trig_pkg::*;
#(
    parameter  int DATA_W    = 14,
    parameter  int N_CH      = 2,
    parameter  int HOLDOFF_W = 16,
    localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clkIn,
    input  logic                   rstnIn,
    input  logic                   en,
    input  logic [N_CH*DATA_W-1:0] adc_data,
    input  logic [N_CH*DATA_W-1:0] threshold,
    input  logic [N_CH*DATA_W-1:0] hysteresis,
    input  logic [SEL_W-1:0]       trig_src,
    input  logic [1:0]             edge_mode,
    input  logic [HOLDOFF_W-1:0]   holdoff,
    input  logic                   auto_rearm,
    input  logic                   arm,
    output logic [N_CH-1:0]        q,
    output logic [N_CH-1:0]        z,
    output logic [N_CH-1:0]        rise,
    output logic [N_CH-1:0]        fall,
    output logic                   armed,
    output logic                   trig,
    output logic [SEL_W-1:0]       trig_ch
);

    logic [N_CH-1:0]      w_q;
    logic [N_CH-1:0]      w_z;
    logic [N_CH-1:0]      w_rise;
    logic [N_CH-1:0]      w_fall;
    logic                 w_hit;
    logic                 w_fire;
    logic                 w_latch;
    trig_state_t          r_state;
    trig_state_t          w_state_nxt;
    logic [HOLDOFF_W-1:0] r_cnt;
    logic [HOLDOFF_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0]     r_src;
    logic [1:0]           r_mode;
    logic                 r_trig;
    logic [SEL_W-1:0]     r_trig_ch;

    genvar g;
    for (g = 0; g < N_CH; g++) begin : g_ch
        hyst_channel #(
            .DATA_W (DATA_W)
        ) u_ch (
            .i_clk    (clkIn),
            .i_rst_n  (rstnIn),
            .i_en     (en),
            .i_sample (adc_data[g*DATA_W +: DATA_W]),
            .i_thr    (threshold[g*DATA_W +: DATA_W]),
            .i_hyst   (hysteresis[g*DATA_W +: DATA_W]),
            .o_q      (w_q[g]),
            .o_z      (w_z[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    // Edge match on the latched channel; an out-of-range source never matches.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == r_src) begin
                case (r_mode)
                    EDGE_RISE: w_hit = w_rise[i];
                    EDGE_FALL: w_hit = w_fall[i];
                    EDGE_BOTH: w_hit = w_rise[i] | w_fall[i];
                    default:   w_hit = 1'b0;
                endcase
            end
        end
    end

    // Next-state, holdoff countdown and trigger decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        w_latch     = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        w_state_nxt = ARMED;
                        w_latch     = 1'b1;
                    end
                end
                ARMED: begin
                    if (w_hit) begin
                        w_fire = 1'b1;
                        if (holdoff == '0) begin
                            w_state_nxt = auto_rearm ? ARMED : IDLE;
                        end else begin
                            w_cnt_nxt   = holdoff;
                            w_state_nxt = HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    if (r_cnt <= HOLDOFF_W'(1)) begin
                        w_state_nxt = auto_rearm ? ARMED : IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - HOLDOFF_W'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Holdoff counter, arm-time latches and trigger outputs.
    always_ff @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) begin
            r_cnt     <= '0;
            r_src     <= '0;
            r_mode    <= 2'b00;
            r_trig    <= 1'b0;
            r_trig_ch <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_trig <= w_fire;
            if (w_fire) r_trig_ch <= r_src;
            if (w_latch) begin
                r_src  <= trig_src;
                r_mode <= edge_mode;
            end
        end
    end

    assign q       = w_q;
    assign z       = w_z;
    assign rise    = w_rise;
    assign fall    = w_fall;
    assign armed   = (r_state == ARMED);
    assign trig    = r_trig;
    assign trig_ch = r_trig_ch;

endmodule

// File: tb/tb_trig_comparator_multi.sv
// Directed bench for trig_comparator_multi (DATA_W=14, N_CH=2).
module tb_trig_comparator_multi;
    import trig_pkg::*;

    localparam int DW = 14;
    localparam int NC = 2;

    logic           clkIn = 1'b0;
    logic           rstnIn;
    logic           en;
    logic [NC*DW-1:0] adc_data;
    logic [NC*DW-1:0] threshold;
    logic [NC*DW-1:0] hysteresis;
    logic [0:0]     trig_src;
    logic [1:0]     edge_mode;
    logic [15:0]    holdoff;
    logic           auto_rearm;
    logic           arm;
    logic [NC-1:0]  q;
    logic [NC-1:0]  z;
    logic [NC-1:0]  rise;
    logic [NC-1:0]  fall;
    logic           armed;
    logic           trig;
    logic [0:0]     trig_ch;

    int n_tests;
    int n_fail;

    trig_comparator_multi #(
        .DATA_W    (DW),
        .N_CH      (NC),
        .HOLDOFF_W (16)
    ) dut (
        .clkIn      (clkIn),
        .rstnIn     (rstnIn),
        .en         (en),
        .adc_data   (adc_data),
        .threshold  (threshold),
        .hysteresis (hysteresis),
        .trig_src   (trig_src),
        .edge_mode  (edge_mode),
        .holdoff    (holdoff),
        .auto_rearm (auto_rearm),
        .arm        (arm),
        .q          (q),
        .z          (z),
        .rise       (rise),
        .fall       (fall),
        .armed      (armed),
        .trig       (trig),
        .trig_ch    (trig_ch)
    );

    always #5 clkIn = ~clkIn;

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_smp(input int ch, input int v);
        adc_data[ch*DW +: DW] = DW'(v);
    endtask

    task automatic set_win(input int ch, input int thr, input int hyst);
        threshold[ch*DW +: DW]  = DW'(thr);
        hysteresis[ch*DW +: DW] = DW'(hyst);
    endtask

    task automatic do_arm(input logic src, input logic [1:0] mode,
                          input int hold, input logic auto_r);
        trig_src   = src;
        edge_mode  = mode;
        holdoff    = 16'(hold);
        auto_rearm = auto_r;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    initial begin
        int prev;
        n_tests    = 0;
        n_fail     = 0;
        rstnIn     = 1'b0;
        en         = 1'b1;
        adc_data   = '0;
        threshold  = '0;
        hysteresis = '0;
        trig_src   = 1'b0;
        edge_mode  = EDGE_RISE;
        holdoff    = '0;
        auto_rearm = 1'b0;
        arm        = 1'b0;
        set_win(0, 8000, 100);
        set_smp(0, 7800);
        set_win(1, 1000, 10);
        set_smp(1, 0);

        // Reset state
        repeat (3) tick();
        chk ("rst_q",       32'(q),       32'd0);
        chk ("rst_z",       32'(z),       32'd0);
        chk ("rst_rise",    32'(rise),    32'd0);
        chk ("rst_fall",    32'(fall),    32'd0);
        chkb("rst_armed",   armed,        1'b0);
        chkb("rst_trig",    trig,         1'b0);
        chkb("rst_trig_ch", trig_ch[0],   1'b0);
        rstnIn = 1'b1;
        repeat (3) tick();
        chkb("idle_q0", q[0], 1'b0);

        // 1: ramp up then down through thr=8000 +/- 100
        prev = -1;
        for (int s = 7800; s <= 8200; s++) begin
            set_smp(0, s);
            tick();
            if (prev >= 0) begin
                chkb("up_z",    z[0],    (prev >= 7900 && prev <= 8100));
                chkb("up_q",    q[0],    (prev >= 8101));
                chkb("up_rise", rise[0], (prev == 8101));
                chkb("up_fall", fall[0], 1'b0);
            end
            prev = s;
        end
        for (int s = 8199; s >= 7800; s--) begin
            set_smp(0, s);
            tick();
            chkb("dn_z",    z[0],    (prev >= 7900 && prev <= 8100));
            chkb("dn_q",    q[0],    (prev >= 7900));
            chkb("dn_fall", fall[0], (prev == 7899));
            chkb("dn_rise", rise[0], 1'b0);
            prev = s;
        end
        chkb("ramp_trig", trig, 1'b0);

        // 2: saturation at the top and bottom of the range
        set_win(0, 16300, 200);
        set_smp(0, 16000);
        repeat (3) tick();
        chkb("sat_hi_q_pre", q[0], 1'b0);
        chkb("sat_hi_z_pre", z[0], 1'b0);
        set_smp(0, 16383);
        repeat (2) tick();
        chkb("sat_hi_z",    z[0],    1'b1);
        chkb("sat_hi_q",    q[0],    1'b0);
        chkb("sat_hi_rise", rise[0], 1'b0);
        repeat (3) tick();
        chkb("sat_hi_q_hold", q[0], 1'b0);
        chkb("sat_hi_z_hold", z[0], 1'b1);
        set_win(0, 50, 100);
        set_smp(0, 200);
        repeat (3) tick();
        chkb("sat_lo_q_pre", q[0], 1'b1);
        set_smp(0, 0);
        repeat (2) tick();
        chkb("sat_lo_z",    z[0],    1'b1);
        chkb("sat_lo_q",    q[0],    1'b1);
        chkb("sat_lo_fall", fall[0], 1'b0);
        repeat (3) tick();
        chkb("sat_lo_q_hold", q[0], 1'b1);

        // 3: first decisive sample after reset sets q without an edge
        rstnIn = 1'b0;
        set_win(0, 8000, 0);
        set_smp(0, 8000);
        repeat (3) tick();
        chkb("pr_q_rst", q[0], 1'b0);
        rstnIn = 1'b1;
        set_smp(0, 9000);
        do_arm(1'b0, EDGE_RISE, 0, 1'b0);
        chkb("pr_armed", armed, 1'b1);
        chkb("pr_z_eq",  z[0],  1'b1);
        chkb("pr_q_n1",  q[0],  1'b0);
        tick();
        chkb("pr_q_n2",    q[0],    1'b1);
        chkb("pr_rise_n2", rise[0], 1'b0);
        tick();
        chkb("pr_trig_n3", trig, 1'b0);
        tick();
        chkb("pr_trig_n4", trig, 1'b0);

        // en=0 returns the FSM to IDLE
        en = 1'b0;
        tick();
        chkb("en0_armed", armed, 1'b0);
        en = 1'b1;
        tick();

        // 4: ch1 rising, holdoff=5, auto re-arm
        do_arm(1'b1, EDGE_RISE, 5, 1'b1);
        chkb("h_armed0", armed, 1'b1);
        set_smp(1, 2000);
        tick();
        chkb("h_trig_e1", trig, 1'b0);
        tick();
        chkb("h_rise_e2",  rise[1], 1'b1);
        chkb("h_trig_e2",  trig,    1'b0);
        chkb("h_armed_e2", armed,   1'b1);
        tick();
        chkb("h_trig_e3",  trig,       1'b1);
        chkb("h_trch_e3",  trig_ch[0], 1'b1);
        chkb("h_armed_e3", armed,      1'b0);
        set_smp(1, 0);
        tick();
        chkb("h_trig_e4",  trig,  1'b0);
        chkb("h_armed_e4", armed, 1'b0);
        set_smp(1, 2000);
        tick();
        chkb("h_armed_e5", armed,   1'b0);
        chkb("h_fall_e5",  fall[1], 1'b1);
        tick();
        chkb("h_armed_e6", armed,   1'b0);
        chkb("h_rise_e6",  rise[1], 1'b1);
        tick();
        chkb("h_armed_e7", armed, 1'b0);
        chkb("h_trig_e7",  trig,  1'b0);
        tick();
        chkb("h_armed_e8", armed, 1'b1);
        chkb("h_trig_e8",  trig,  1'b0);
        tick();
        chkb("h_trig_e9",  trig,  1'b0);

        // 5: either-edge, no holdoff, no re-arm
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        chkb("e_idle", armed, 1'b0);
        do_arm(1'b1, EDGE_BOTH, 0, 1'b0);
        chkb("e_armed", armed, 1'b1);
        set_smp(1, 0);
        repeat (2) tick();
        chkb("e_fall", fall[1], 1'b1);
        chkb("e_trig_pre", trig, 1'b0);
        tick();
        chkb("e_trig",    trig,       1'b1);
        chkb("e_trch",    trig_ch[0], 1'b1);
        chkb("e_armed_0", armed,      1'b0);
        tick();
        chkb("e_trig_once", trig, 1'b0);
        set_smp(1, 2000);
        repeat (2) tick();
        chkb("e_rise2", rise[1], 1'b1);
        tick();
        chkb("e_trig2",   trig,  1'b0);
        chkb("e_armed_2", armed, 1'b0);
        tick();
        chkb("e_trig2b", trig, 1'b0);

        // 6: async reset in HOLDOFF with the counter at 3
        do_arm(1'b1, EDGE_BOTH, 5, 1'b0);
        chkb("r_armed", armed, 1'b1);
        set_smp(1, 0);
        repeat (3) tick();
        chkb("r_trig", trig, 1'b1);
        set_smp(0, 8000);
        repeat (2) tick();
        chkb("r_q0_pre",   q[0],       1'b1);
        chkb("r_z0_pre",   z[0],       1'b1);
        chkb("r_trch_pre", trig_ch[0], 1'b1);
        #2;
        rstnIn = 1'b0;
        #1;
        chk ("r_q",     32'(q),     32'd0);
        chk ("r_z",     32'(z),     32'd0);
        chk ("r_rise",  32'(rise),  32'd0);
        chk ("r_fall",  32'(fall),  32'd0);
        chkb("r_armed0", armed,     1'b0);
        chkb("r_trig0",  trig,      1'b0);
        chkb("r_trch0",  trig_ch[0], 1'b0);
        repeat (3) tick();
        rstnIn = 1'b1;
        repeat (2) tick();
        set_smp(1, 2000);
        repeat (2) tick();
        chkb("r_rise_post", rise[1], 1'b1);
        tick();
        chkb("r_trig_post",  trig,  1'b0);
        chkb("r_armed_post", armed, 1'b0);
        tick();
        chkb("r_trig_post2", trig, 1'b0);
        do_arm(1'b1, EDGE_BOTH, 0, 1'b0);
        chkb("r_rearm", armed, 1'b1);
        en = 1'b0;
        tick();
        chkb("r_en0_armed", armed, 1'b0);
        en = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_comparator_multi.md
Name: trig_comparator_multi

Overview:
Multi-channel hysteresis comparator with edge detection and an armed trigger engine. It sits between the ADC capture path and acquisition control. Each channel compares ADC samples against a per-channel threshold ± hysteresis band and produces a level and a dead-zone flag. A shared FSM turns a selected channel's edges into a single-cycle trigger pulse with holdoff and optional auto re-arm.

Parameters:
DATA_W, 14, ADC sample/threshold/hysteresis width (unsigned)
N_CH, 2, number of comparator channels
HOLDOFF_W, 16, holdoff counter width
SEL_W, $clog2(N_CH) (min 1), trigger-source select width (derived, not overridden)

Ports:
clkIn  in  1  sole clock; all logic on rising edge
rstnIn  in  1  asynchronous active-low reset
en  in  1  block enable
adc_data  in  N_CH*DATA_W  packed samples, channel 0 in LSBs
threshold  in  N_CH*DATA_W  per-channel threshold
hysteresis  in  N_CH*DATA_W  per-channel half-band
trig_src  in  SEL_W  trigger channel, latched at arm
edge_mode  in  2  00 rising, 01 falling, 10 either, 11 disabled; latched at arm
holdoff  in  HOLDOFF_W  holdoff length in cycles, latched at trigger
auto_rearm  in  1  return to ARMED after holdoff instead of IDLE
arm  in  1  single-cycle arm request
q  out  N_CH  per-channel hysteresis level
z  out  N_CH  per-channel dead-zone flag
rise  out  N_CH  single-cycle rising-edge pulse
fall  out  N_CH  single-cycle falling-edge pulse
armed  out  1  high while FSM is ARMED
trig  out  1  single-cycle trigger pulse
trig_ch  out  SEL_W  channel of the last trigger; held until the next trigger

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE, holdoff counter to 0, per-channel valid flags to 0, and the latched src/mode to 0.
- Stage 1 (per channel): register the sample. upper = min(thr+hyst, 2^DATA_W-1) and lower = max(thr-hyst, 0), both computed at DATA_W+1 bits and saturated. No wrap is permitted.
- Stage 2 (per channel):
  - sample > upper: q<=1, z<=0, valid<=1.
  - sample < lower: q<=0, z<=0, valid<=1.
  - otherwise: q holds, z<=1.
- Stage 2 edges: rise/fall are registered with q. rise=1 only if valid was already 1 and q goes 0->1; fall likewise for 1->0. The first decisive sample after reset sets q without an edge.
- Latency: a sample present at clkIn edge N affects q/z/rise/fall at edge N+2, and trig at edge N+3.
- Sample equal to upper or lower is in the dead zone. With hyst=0, a sample equal to thr is also in the dead zone.
- Threshold/hysteresis changes apply from the next stage-1 register; q is not recomputed retroactively.
- FSM states: IDLE, ARMED, HOLDOFF.
  - IDLE: arm=1 -> ARMED; latch trig_src and edge_mode.
  - ARMED: a matching edge on the latched channel raises trig for one cycle and loads trig_ch. Then:
    - holdoff==0: go to ARMED if auto_rearm=1, else IDLE.
    - holdoff!=0: load counter=holdoff and go to HOLDOFF.
  - ARMED: mode 11, or latched src >= N_CH, never triggers.
  - HOLDOFF: decrement the counter each cycle. At 1 -> ARMED if auto_rearm (sampled then), else IDLE. Edges are ignored.
- arm is ignored in ARMED and HOLDOFF. While ARMED, a trigger and an arm in the same cycle resolve as a trigger only.
- en=0:
  - stage registers, q, z and valid hold.
  - rise/fall/trig are forced 0.
  - FSM forced to IDLE, counter cleared.
  - On en rising, no edge is reported from the stale state.
- Reset mid-operation (any state) clears immediately. A new arm is required after release.

Decomposition:
- Shared package trig_pkg:
  - edge-mode constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF).
  - FSM state enum (IDLE, ARMED, HOLDOFF) with explicit 2-bit encoding.
  - saturating add/sub functions.
- One sub-module hyst_channel: stages 1-2 for one channel (q, z, valid, rise, fall). It is instantiated N_CH times via generate. The top level holds the FSM and holdoff counter.

Test Plan:
1. ch0 thr=8000, hyst=100; ramp 7800->8200 step 1, then back down:
   - z=1 for samples 7900..8100.
   - q->1 two cycles after sample 8101 is clocked, with one rise pulse.
   - On the way down, q->0 after 7899, with one fall pulse.
2. Saturation: thr=16300, hyst=200 -> sample 16383 stays z=1 and q never sets. thr=50, hyst=100 -> sample 0 stays z=1 and q never clears. No wrap-induced toggling.
3. Post-reset: release rstnIn, first sample 9000 with thr=8000, hyst=0 -> q=1 at N+2, rise stays 0, no trig even when armed with mode rising.
4. Arm with src=1, mode=rising, holdoff=5, auto_rearm=1:
   - ch1 rise -> trig high exactly 1 cycle, trig_ch=1.
   - armed low 5 cycles; ch1 edges inside holdoff produce no trig.
   - armed returns high after holdoff.
5. mode=either, auto_rearm=0, holdoff=0: fall on src channel -> trig, FSM to IDLE, armed=0. A second edge gives no trig until a new arm.
6. Async reset mid-HOLDOFF (counter=3):
   - q, z, armed, trig, trig_ch go to 0 without a clock edge.
   - After release, edges produce no trig until arm.
   - en=0 during ARMED drops armed on the next edge.
